// File: rtl/wb_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter_if
// Bundles the register-file write-port traffic around wb_write_arbiter.
//   ALU side     : alu_valid, alu_rd[4:0], alu_data[31:0]
//   Load side    : ld_valid, ld_ready, ld_rd[4:0], ld_data[31:0]
//   Issue side   : iss_valid, iss_rd[4:0]
//   Write port   : RegWrite, wr_addr[4:0], wr_data[31:0]
//   Status       : busy_mask[31:0], alu_stall, proto_err
// modport master : the pipeline/upstream logic that feeds the arbiter
// modport slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface wb_write_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;

    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;

    logic        iss_valid;
    logic [4:0]  iss_rd;

    logic        RegWrite;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] busy_mask;
    logic        alu_stall;
    logic        proto_err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output iss_valid, iss_rd,
        input  ld_ready,
        input  RegWrite, wr_addr, wr_data,
        input  busy_mask, alu_stall, proto_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  iss_valid, iss_rd,
        output ld_ready,
        output RegWrite, wr_addr, wr_data,
        output busy_mask, alu_stall, proto_err
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
// Merges single-cycle ALU results and buffered, variable-latency load results
// into the single register-file write port (one write per clock). ALU results
// have priority; a starvation counter raises alu_stall so buffered loads
// always retire. A pending-load scoreboard (busy_mask) feeds hazard logic.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-low
//   bus   : wb_write_arbiter_if.slave (ALU, load, issue, write port, status)
// ---------------------------------------------------------------------------
module wb_write_arbiter #(
    parameter int LD_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    wb_write_arbiter_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int PW     = $clog2(LD_DEPTH);
    localparam int CW     = PW + 1;
    localparam int SW     = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(LD_DEPTH);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    // load-result FIFO storage (data path, never reset)
    logic [4:0]        fifo_rd   [LD_DEPTH];
    logic [DATA_W-1:0] fifo_data [LD_DEPTH];

    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] fill;
    logic [SW-1:0] starve;
    logic          stall;
    logic          perr;
    logic [31:0]   busy;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;
    logic [31:0]   busy_next;
    logic [SW-1:0] starve_next;
    logic          stall_next;

    logic              wr_vld_p0;
    logic [4:0]        wr_addr_p0;
    logic [DATA_W-1:0] wr_data_p0;
    logic              wr_vld_p1;
    logic [4:0]        wr_addr_p1;
    logic [DATA_W-1:0] wr_data_p1;

    assign empty = (fill == '0);
    // Full blocks a push even when the head pops in the same cycle.
    assign full  = (fill == FULL_CNT);
    assign push  = bus.ld_valid & ~full;
    // ALU always wins the port; the FIFO head only drains on idle ALU cycles.
    assign pop   = ~bus.alu_valid & ~empty;

    // ---- stage p0: select the write source ----
    always_comb begin
        wr_vld_p0  = 1'b0;
        wr_addr_p0 = wr_addr_p1;
        wr_data_p0 = wr_data_p1;
        if (bus.alu_valid) begin
            wr_vld_p0  = (bus.alu_rd != 5'd0);
            wr_addr_p0 = bus.alu_rd;
            wr_data_p0 = bus.alu_data;
        end else if (!empty) begin
            wr_vld_p0  = (fifo_rd[head_ptr] != 5'd0);
            wr_addr_p0 = fifo_rd[head_ptr];
            wr_data_p0 = fifo_data[head_ptr];
        end
    end

    // Scoreboard: set applied after clear so a same-register issue wins.
    always_comb begin
        set_mask  = bus.iss_valid ? (32'd1 << bus.iss_rd) : 32'd0;
        clr_mask  = pop ? (32'd1 << fifo_rd[head_ptr]) : 32'd0;
        busy_next = ((busy & ~clr_mask) | set_mask) & ~32'd1;
    end

    // Starvation: count head-waiting cycles; stall holds until the head pops.
    always_comb begin
        starve_next = starve;
        if (empty || pop) begin
            starve_next = '0;
        end else if (starve != STARVE_TOP) begin
            starve_next = starve + SW'(1);
        end
        stall_next = pop ? 1'b0 : (stall | (starve == STARVE_TOP));
    end

    // ---- stage p1: registered write port and control state ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            fill       <= '0;
            starve     <= '0;
            stall      <= 1'b0;
            perr       <= 1'b0;
            busy       <= '0;
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PW'(1);
            if (pop)  head_ptr <= head_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fill <= fill + CW'(1);
                2'b01:   fill <= fill - CW'(1);
                default: fill <= fill;
            endcase
            starve     <= starve_next;
            stall      <= stall_next;
            perr       <= perr | (bus.alu_valid & stall);
            busy       <= busy_next;
            wr_vld_p1  <= wr_vld_p0;
            wr_addr_p1 <= wr_addr_p0;
            wr_data_p1 <= wr_data_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail_ptr]   <= bus.ld_rd;
            fifo_data[tail_ptr] <= bus.ld_data;
        end
    end

    assign bus.ld_ready  = ~full;
    assign bus.RegWrite  = wr_vld_p1;
    assign bus.wr_addr   = wr_addr_p1;
    assign bus.wr_data   = wr_data_p1;
    assign bus.busy_mask = busy;
    assign bus.alu_stall = stall;
    assign bus.proto_err = perr;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_write_arbiter
// Directed scenarios plus randomized traffic for wb_write_arbiter, compared
// every cycle against a queue-based reference model of the write arbiter.
// ---------------------------------------------------------------------------
module tb_wb_write_arbiter;
    localparam int LD_DEPTH   = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_write_arbiter_if bus();

    wb_write_arbiter #(
        .LD_DEPTH  (LD_DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ld_t;

    ld_t         q[$];
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_busy;
    bit          m_stall;
    bit          m_perr;
    int          m_wait;

    task automatic model_edge();
        int          n_before;
        bit          took_pop;
        ld_t         h;
        ld_t         e;
        logic [31:0] clr;
        logic [31:0] setm;
        if (!reset) begin
            q.delete();
            m_we = 0; m_addr = '0; m_data = '0; m_busy = '0;
            m_stall = 0; m_perr = 0; m_wait = 0;
            return;
        end
        n_before = q.size();
        took_pop = 0;
        clr = '0;
        setm = '0;
        if (bus.alu_valid) begin
            m_we = (bus.alu_rd != 0);
            m_addr = bus.alu_rd;
            m_data = bus.alu_data;
        end else if (n_before > 0) begin
            h = q.pop_front();
            took_pop = 1;
            m_we = (h.rd != 0);
            m_addr = h.rd;
            m_data = h.d;
            clr[h.rd] = 1'b1;
        end else begin
            m_we = 0;
        end
        if (bus.ld_valid && n_before < LD_DEPTH) begin
            e.rd = bus.ld_rd;
            e.d = bus.ld_data;
            q.push_back(e);
        end
        if (bus.iss_valid) setm[bus.iss_rd] = 1'b1;
        m_busy = (m_busy & ~clr) | setm;
        m_busy[0] = 1'b0;
        m_perr = m_perr | (bus.alu_valid && m_stall);
        if (took_pop) m_stall = 0;
        else if (m_wait == STARVE_MAX) m_stall = 1;
        if (n_before > 0 && !took_pop) m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
        else m_wait = 0;
    endtask

    task automatic compare_all();
        chk("RegWrite", bus.RegWrite, m_we);
        chk("wr_addr", bus.wr_addr, m_addr);
        chk("wr_data", bus.wr_data, m_data);
        chk("busy_mask", bus.busy_mask, m_busy);
        chk("ld_ready", bus.ld_ready, q.size() < LD_DEPTH);
        chk("alu_stall", bus.alu_stall, m_stall);
        chk("proto_err", bus.proto_err, m_perr);
    endtask

    // Inputs are stable at the negedge; model advances, then DUT is sampled
    // at the following negedge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid = 0; bus.ld_rd = '0; bus.ld_data = '0;
        bus.iss_valid = 0; bus.iss_rd = '0;
    endtask

    task automatic rand_inputs(input bit obey_stall);
        if (m_stall && obey_stall) bus.alu_valid = ($urandom_range(15) == 0);
        else bus.alu_valid = $urandom_range(1);
        bus.alu_rd = 5'($urandom);
        bus.alu_data = $urandom;
        bus.ld_valid = $urandom_range(1);
        bus.ld_rd = 5'($urandom);
        bus.ld_data = $urandom;
        bus.iss_valid = ($urandom_range(9) < 3);
        bus.iss_rd = 5'($urandom);
    endtask

    initial begin
        idle();
        // reset with random inputs
        reset = 0;
        rand_inputs(0); cycle();
        rand_inputs(0); cycle();
        chk("rst_RegWrite", bus.RegWrite, 0);
        chk("rst_busy", bus.busy_mask, 0);
        chk("rst_ld_ready", bus.ld_ready, 1);
        chk("rst_stall", bus.alu_stall, 0);
        chk("rst_perr", bus.proto_err, 0);
        reset = 1;
        idle(); cycle();

        // ALU only
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
        cycle();
        chk("alu_we", bus.RegWrite, 1);
        chk("alu_addr", bus.wr_addr, 5);
        chk("alu_data", bus.wr_data, 32'hDEADBEEF);
        bus.alu_rd = 0; bus.alu_data = 32'h55;
        cycle();
        chk("alu_x0_we", bus.RegWrite, 0);
        idle(); cycle();

        // load and scoreboard
        bus.iss_valid = 1; bus.iss_rd = 7;
        cycle();
        idle();
        chk("sb_set", bus.busy_mask, 32'h80);
        bus.ld_valid = 1; bus.ld_rd = 7; bus.ld_data = 32'h1234;
        cycle();
        idle();
        chk("ld_lat_early", bus.RegWrite, 0);
        cycle();
        chk("ld_we", bus.RegWrite, 1);
        chk("ld_addr", bus.wr_addr, 7);
        chk("ld_data", bus.wr_data, 32'h1234);
        cycle();
        chk("sb_clr", bus.busy_mask, 0);

        // FIFO full with ALU busy
        bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'h3;
        bus.ld_valid = 1; bus.ld_rd = 10; bus.ld_data = 32'hA0A0;
        cycle();
        bus.ld_rd = 11; bus.ld_data = 32'hB0B0;
        cycle();
        chk("full_ready", bus.ld_ready, 0);
        bus.ld_rd = 12; bus.ld_data = 32'hC0C0;
        cycle();
        chk("full_hold", bus.ld_ready, 0);
        idle();
        cycle();
        chk("full_first_addr", bus.wr_addr, 10);
        chk("full_first_data", bus.wr_data, 32'hA0A0);
        cycle();
        chk("full_second_addr", bus.wr_addr, 11);
        chk("full_second_data", bus.wr_data, 32'hB0B0);
        chk("full_ready_back", bus.ld_ready, 1);
        cycle();

        // starvation, compliant upstream
        bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 32'h4;
        bus.ld_valid = 1; bus.ld_rd = 13; bus.ld_data = 32'hD0D0;
        cycle();
        bus.ld_valid = 0;
        for (int i = 0; i < STARVE_MAX; i++) begin
            cycle();
            chk("starve_nostall", bus.alu_stall, 0);
        end
        cycle();
        chk("starve_stall", bus.alu_stall, 1);
        chk("starve_noperr", bus.proto_err, 0);
        idle();
        cycle();
        chk("starve_pop_addr", bus.wr_addr, 13);
        chk("starve_release", bus.alu_stall, 0);

        // starvation with protocol violation
        bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 32'h44;
        bus.ld_valid = 1; bus.ld_rd = 14; bus.ld_data = 32'hE0E0;
        cycle();
        bus.ld_valid = 0;
        for (int i = 0; i < STARVE_MAX + 2; i++) cycle();
        chk("perr_set", bus.proto_err, 1);
        idle();
        for (int i = 0; i < 3; i++) cycle();
        chk("perr_sticky", bus.proto_err, 1);

        // set wins over clear on the same register
        bus.iss_valid = 1; bus.iss_rd = 9;
        cycle();
        idle();
        bus.ld_valid = 1; bus.ld_rd = 9; bus.ld_data = 32'h9999;
        cycle();
        idle();
        bus.iss_valid = 1; bus.iss_rd = 9;
        cycle();
        idle();
        chk("sb_set_wins", bus.busy_mask[9], 1);
        chk("sb_pop_wr", bus.wr_addr, 9);

        // reset discards buffered loads
        bus.alu_valid = 1; bus.alu_rd = 2; bus.alu_data = 32'h2;
        bus.ld_valid = 1; bus.ld_rd = 20; bus.ld_data = 32'h20;
        cycle();
        bus.ld_rd = 21; bus.ld_data = 32'h21;
        cycle();
        idle();
        reset = 0;
        cycle();
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rst_discard", bus.RegWrite, 0);
        end

        // randomized traffic, occasional reset
        for (int i = 0; i < 3000; i++) begin
            rand_inputs(1);
            reset = ($urandom_range(199) != 0);
            cycle();
        end
        reset = 1;
        idle();
        for (int i = 0; i < 8; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
